// File: rtl/sum_accum.sv
// Batch accumulator for 5-bit adder results: N_SUMS transfers, then hold for the consumer.
// Define SUM_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module sum_accum #(
    parameter int N_SUMS = 4,
    parameter int ACC_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [3:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(N_SUMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       count_q, count_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [ACC_W:0]   sum_w;

    // One extra bit catches the carry out of the accumulator.
    assign sum_w = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, in_sum};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = 4'd0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef SUM_ACCUM_SAT_EN
                    acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
                    acc_d = sum_w[ACC_W-1:0];
`endif
                    ovf_d   = ovf_q | sum_w[ACC_W];
                    count_d = count_q + 4'd1;
                    if (count_q == LAST_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they never see an input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc       = acc_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: 8-bit and 6-bit instances share stimulus,
// both checked every cycle against an arithmetic model plus literal expectations.
module tb_sum_accum;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] in_sum;
    logic       in_valid;
    logic       out_ready;

    logic       ir8, ov8, vo8, bz8;
    logic [7:0] a8;
    logic [3:0] c8;
    logic       ir6, ov6, vo6, bz6;
    logic [5:0] a6;
    logic [3:0] c6;

    int errors = 0;
    int checks = 0;

    int ph  = 0;
    int m8  = 0;
    int m6  = 0;
    int mc  = 0;
    bit o8  = 0;
    bit o6  = 0;

    int e6 [4];
    int eo [4];

    always #5 clk = ~clk;

    sum_accum #(.N_SUMS(N), .ACC_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_sum(in_sum),
        .in_valid(in_valid), .in_ready(ir8), .acc(a8), .ovf(ov8),
        .count(c8), .out_valid(vo8), .out_ready(out_ready), .busy(bz8)
    );

    sum_accum #(.N_SUMS(N), .ACC_W(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_sum(in_sum),
        .in_valid(in_valid), .in_ready(ir6), .acc(a6), .ovf(ov6),
        .count(c6), .out_valid(vo6), .out_ready(out_ready), .busy(bz6)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(inout int a, inout bit o, input int s, input int w);
        int lim;
        int t;
        lim = 1 << w;
        t = a + s;
        if (t >= lim) begin
            o = 1'b1;
`ifdef SUM_ACCUM_SAT_EN
            t = lim - 1;
`else
            t = t - lim;
`endif
        end
        a = t;
    endfunction

    // Model: phase 0 idle, 1 accumulating, 2 holding the result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; m8 = 0; m6 = 0; mc = 0; o8 = 0; o6 = 0;
        end else begin
            case (ph)
                0: if (start) begin
                    ph = 1; m8 = 0; m6 = 0; mc = 0; o8 = 0; o6 = 0;
                end
                1: if (in_valid) begin
                    add(m8, o8, int'(in_sum), 8);
                    add(m6, o6, int'(in_sum), 6);
                    mc++;
                    if (mc == N) ph = 2;
                end
                2: if (out_ready) ph = 0;
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("acc8", int'(a8), m8);
        chk("ovf8", int'(ov8), int'(o8));
        chk("cnt8", int'(c8), mc);
        chk("ird8", int'(ir8), int'(ph == 1));
        chk("ovl8", int'(vo8), int'(ph == 2));
        chk("bsy8", int'(bz8), int'(ph != 0));
        chk("acc6", int'(a6), m6);
        chk("ovf6", int'(ov6), int'(o6));
        chk("cnt6", int'(c6), mc);
        chk("ird6", int'(ir6), int'(ph == 1));
        chk("ovl6", int'(vo6), int'(ph == 2));
        chk("bsy6", int'(bz6), int'(ph != 0));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef SUM_ACCUM_SAT_EN
        e6 = '{31, 62, 63, 63};
`else
        e6 = '{31, 62, 29, 60};
`endif
        eo = '{0, 0, 1, 1};
        rst_n = 1'b1; start = 1'b0; in_sum = 5'd0;
        in_valid = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_acc", int'(a8), 0);
        chk("rst_busy", int'(bz8), 0);
        chk("rst_ird", int'(ir8), 0);
        tick; tick;

        // Start on the very first edge after reset release.
        rst_n = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk("a_inready", int'(ir8), 1);
        in_valid = 1'b1; in_sum = 5'd14;
        repeat (3) tick;
        chk("a_novalid3", int'(vo8), 0);
        tick;
        in_valid = 1'b0;
        chk("a_acc", int'(a8), 56);
        chk("a_cnt", int'(c8), 4);
        chk("a_ovf", int'(ov8), 0);
        chk("a_oval", int'(vo8), 1);
        chk("a_acc6", int'(a6), 56);
        tick;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("a_idle", int'(bz8), 0);
        chk("a_kept", int'(a8), 56);

        // Overflow: 31 x 4 on the 6-bit instance.
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_sum = 5'd31;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("b_acc6_%0d", i), int'(a6), e6[i]);
            chk($sformatf("b_ovf6_%0d", i), int'(ov6), eo[i]);
        end
        in_valid = 1'b0;
        chk("b_acc8", int'(a8), 124);

        // Hold for 5 cycles, with a start pulse that must be ignored.
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick;
            chk($sformatf("h_acc6_%0d", i), int'(a6), e6[3]);
            chk($sformatf("h_oval_%0d", i), int'(vo6), 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("h_idle", int'(bz6), 0);

        // in_valid toggling; off-cycle sums are junk and must be skipped.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_sum = in_valid ? 5'(i / 2 + 1) : 5'd7;
            tick;
        end
        in_valid = 1'b0;
        chk("c_acc", int'(a8), 10);
        chk("c_cnt", int'(c8), 4);
        chk("c_oval", int'(vo8), 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Reset mid-batch, then a fresh batch of 4 x 5.
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_sum = 5'd5;
        tick; tick;
        chk("d_part", int'(a8), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("d_racc", int'(a8), 0);
        chk("d_rcnt", int'(c8), 0);
        chk("d_rbsy", int'(bz8), 0);
        chk("d_rird", int'(ir8), 0);
        chk("d_racc6", int'(a6), 0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("d_idle_cnt", int'(c8), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        in_valid = 1'b0;
        chk("d_acc", int'(a8), 20);
        chk("d_acc6", int'(a6), 20);
        chk("d_oval", int'(vo8), 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
